// File: rtl/div_unit_pkg.sv
// ----------------------------------------------------------------------------
// div_unit_pkg
// Shared types and constants for the execute-stage integer divider.
//   div_func_t  : DIV=0, DIVU=1, REM=2, REMU=3
//   div_state_t : IDLE, BUSY, DONE
//   mag()       : conditional two's-complement negate, used for operand
//                 magnitudes and for restoring result signs
// ----------------------------------------------------------------------------
package div_unit_pkg;

   localparam int unsigned DIV_XLEN  = 64;
   localparam int unsigned DIV_ITERS = 64;

   typedef enum logic [1:0] {
      F_DIV  = 2'd0,
      F_DIVU = 2'd1,
      F_REM  = 2'd2,
      F_REMU = 2'd3
   } div_func_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   function automatic logic [DIV_XLEN-1:0] mag(input logic neg,
                                                input logic [DIV_XLEN-1:0] v);
      return neg ? (-v) : v;
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// ----------------------------------------------------------------------------
// div_unit_if
// Request/response bundle between operand formation and the divider.
//   in_valid/in_ready   : request handshake (a, b, func, word)
//   out_valid/out_ready : response handshake (result)
//   busy                : divider occupied, drives pipeline stall
// master = requester side, slave = div_unit side.
// ----------------------------------------------------------------------------
interface div_unit_if #(
   parameter int unsigned XLEN = 64
);
   import div_unit_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   div_func_t       func;
   logic            word;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output in_valid, a, b, func, word, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, a, b, func, word, out_ready,
      output in_ready, out_valid, result, busy
   );

endinterface

// File: rtl/div_unit_core_u64.sv
// ----------------------------------------------------------------------------
// div_core_u64
// Unsigned 64-bit restoring divider, one shift-subtract step per cycle.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   flush        : abandon the current operation
//   start        : load dividend/divisor and begin ITERS iterations
//   dividend     : unsigned dividend
//   divisor      : unsigned divisor (held internally)
//   quotient     : quotient, valid the cycle after done
//   remainder    : remainder, valid the cycle after done
//   done         : high during the final iteration
// ----------------------------------------------------------------------------
module div_core_u64
   import div_unit_pkg::*;
#(
   parameter int unsigned ITERS = DIV_ITERS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        start,
   input  logic [63:0] dividend,
   input  logic [63:0] divisor,
   output logic [63:0] quotient,
   output logic [63:0] remainder,
   output logic        done
);

   localparam int unsigned CW = $clog2(ITERS);

   logic [63:0]   quo;
   logic [63:0]   rem;
   logic [63:0]   dvs;
   logic [CW-1:0] cnt;
   logic          running;
   logic [64:0]   rem_sh;
   logic [64:0]   diff;

   // Quotient bits are shifted into quo as dividend bits shift out of it.
   always_comb begin
      rem_sh = {rem, quo[63]};
      diff   = rem_sh - {1'b0, dvs};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         quo     <= '0;
         rem     <= '0;
         dvs     <= '0;
         cnt     <= '0;
         running <= 1'b0;
      end else if (flush) begin
         running <= 1'b0;
      end else if (start) begin
         quo     <= dividend;
         rem     <= '0;
         dvs     <= divisor;
         cnt     <= CW'(ITERS - 1);
         running <= 1'b1;
      end else if (running) begin
         // diff[64] set means the trial subtraction underflowed: restore.
         if (!diff[64]) begin
            rem <= diff[63:0];
            quo <= {quo[62:0], 1'b1};
         end else begin
            rem <= rem_sh[63:0];
            quo <= {quo[62:0], 1'b0};
         end
         if (cnt == '0) begin
            running <= 1'b0;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign done      = running && (cnt == '0);
   assign quotient  = quo;
   assign remainder = rem;

endmodule

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
// Multi-cycle 64-bit DIV/DIVU/REM/REMU (and W forms) for the execute stage.
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset
//   flush  : abort in-flight operation, return to IDLE
//   bus    : div_unit_if.slave (in_valid/in_ready, a, b, func, word,
//            out_valid/out_ready, result, busy)
// Optional build macro DIV_FAST_PATH_EN: divide-by-zero and signed overflow
// skip the iterative core and go straight to DONE.
// ----------------------------------------------------------------------------
module div_unit
   import div_unit_pkg::*;
#(
   parameter int unsigned XLEN  = DIV_XLEN,
   parameter int unsigned ITERS = DIV_ITERS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   div_unit_if.slave  bus
);

`ifdef DIV_FAST_PATH_EN
   localparam bit FAST_PATH = 1'b1;
`else
   localparam bit FAST_PATH = 1'b0;
`endif

   div_state_t      state, state_nxt;

   logic            accept;
   logic            is_signed_in, is_rem_in;
   logic            a_neg_in, b_neg_in;
   logic            div0_in, ovf_in, special_in;
   logic [XLEN-1:0] a_mag_in, b_mag_in;

   logic [XLEN-1:0] a_raw;
   logic            is_rem_q, word_q, neg_q_q, neg_r_q, div0_q, ovf_q;

   logic            core_start, core_done;
   logic [XLEN-1:0] core_quo, core_rem;

   logic [XLEN-1:0] q_fix, r_fix, sel, final_res;
   logic [XLEN-1:0] result_q;
   logic            out_valid_q;

   // Operand decode at the accept boundary
   always_comb begin
      accept       = bus.in_valid && (state == IDLE) && !flush;
      is_signed_in = (bus.func == F_DIV) || (bus.func == F_REM);
      is_rem_in    = (bus.func == F_REM) || (bus.func == F_REMU);
      a_neg_in     = is_signed_in && bus.a[XLEN-1];
      b_neg_in     = is_signed_in && bus.b[XLEN-1];
      a_mag_in     = mag(a_neg_in, bus.a);
      b_mag_in     = mag(b_neg_in, bus.b);
      div0_in      = (bus.b == '0);
      ovf_in       = is_signed_in && (bus.a == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.b == '1);
      special_in   = div0_in || ovf_in;
      core_start   = accept && !(FAST_PATH && special_in);
   end

   div_core_u64 #(
      .ITERS (ITERS)
   ) u_core (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .start     (core_start),
      .dividend  (a_mag_in),
      .divisor   (b_mag_in),
      .quotient  (core_quo),
      .remainder (core_rem),
      .done      (core_done)
   );

   // Sign fix, special-case override, then W-form extension
   always_comb begin
      q_fix = mag(neg_q_q, core_quo);
      r_fix = mag(neg_r_q, core_rem);
      if (div0_q) begin
         q_fix = '1;
         r_fix = a_raw;
      end else if (ovf_q) begin
         q_fix = a_raw;
         r_fix = '0;
      end
      sel       = is_rem_q ? r_fix : q_fix;
      final_res = word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
   end

   // FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (FAST_PATH && special_in) ? DONE : BUSY;
         BUSY: if (core_done) state_nxt = DONE;
         DONE: if (out_valid_q && bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt = IDLE;
      end
   end

   // The first DONE cycle registers the result; out_valid rises after it,
   // so both paths present a registered, stable result.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_raw       <= '0;
         is_rem_q    <= 1'b0;
         word_q      <= 1'b0;
         neg_q_q     <= 1'b0;
         neg_r_q     <= 1'b0;
         div0_q      <= 1'b0;
         ovf_q       <= 1'b0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            a_raw    <= bus.a;
            is_rem_q <= is_rem_in;
            word_q   <= bus.word;
            neg_q_q  <= a_neg_in ^ b_neg_in;
            neg_r_q  <= a_neg_in;
            div0_q   <= div0_in;
            ovf_q    <= ovf_in;
         end
         if (flush) begin
            out_valid_q <= 1'b0;
         end else if (state == DONE) begin
            if (!out_valid_q) begin
               result_q    <= final_res;
               out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
               out_valid_q <= 1'b0;
            end
         end
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit
// Directed self-checking bench for div_unit. Honours DIV_FAST_PATH_EN for the
// expected latency of divide-by-zero and signed-overflow operations.
// ----------------------------------------------------------------------------
module tb_div_unit;
   import div_unit_pkg::*;

`ifdef DIV_FAST_PATH_EN
   localparam int SPECIAL_LAT = 1;
`else
   localparam int SPECIAL_LAT = 65;
`endif
   localparam int NORMAL_LAT = 65;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   int   checks = 0;
   int   errors = 0;

   div_unit_if #(.XLEN(64)) bus ();

   div_unit dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue(input div_func_t f, input logic w,
                        input logic [63:0] av, input logic [63:0] bv);
      bus.func     = f;
      bus.word     = w;
      bus.a        = av;
      bus.b        = bv;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat, output logic busy_ok);
      lat     = 0;
      busy_ok = 1'b1;
      while (!bus.out_valid && lat < 200) begin
         if (!bus.busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.busy) busy_ok = 1'b0;
   endtask

   task automatic run_op(input div_func_t f, input logic w,
                         input logic [63:0] av, input logic [63:0] bv,
                         output logic [63:0] res, output int lat,
                         output logic busy_ok);
      issue(f, w, av, bv);
      wait_valid(lat, busy_ok);
      res           = bus.result;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1
          || bus.result !== 64'h0) begin
         errors++;
         $display("FAIL reset: out_valid=%b busy=%b in_ready=%b result=%h, expected 0 0 1 0",
                  bus.out_valid, bus.busy, bus.in_ready, bus.result);
      end
   endtask

   task automatic test_div_basic;
      logic [63:0] res;
      int          lat;
      logic        bok;
      run_op(F_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, res, lat, bok);
      checks++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         errors++;
         $display("FAIL div_neg7_2: got %h expected %h", res, 64'hFFFF_FFFF_FFFF_FFFD);
      end
      checks++;
      if (lat !== NORMAL_LAT) begin
         errors++;
         $display("FAIL div_latency: got %0d expected %0d", lat, NORMAL_LAT);
      end
      checks++;
      if (bok !== 1'b1) begin
         errors++;
         $display("FAIL div_busy: busy dropped during operation (got %b expected 1)", bok);
      end
      checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL div_release: in_ready=%b busy=%b expected 1 0", bus.in_ready, bus.busy);
      end
   endtask

   task automatic test_ops;
      div_func_t   fv [8];
      logic [63:0] av [8];
      logic [63:0] bv [8];
      logic [63:0] ev [8];
      logic [63:0] res;
      int          lat;
      logic        bok;
      fv[0] = F_REM;  av[0] = 64'hFFFF_FFFF_FFFF_FFF9; bv[0] = 64'd2;  ev[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      fv[1] = F_REMU; av[1] = 64'd7;                   bv[1] = 64'd2;  ev[1] = 64'd1;
      fv[2] = F_DIVU; av[2] = 64'd100;                 bv[2] = 64'd7;  ev[2] = 64'd14;
      fv[3] = F_DIV;  av[3] = 64'd7;                   bv[3] = 64'hFFFF_FFFF_FFFF_FFFE; ev[3] = 64'hFFFF_FFFF_FFFF_FFFD;
      fv[4] = F_REM;  av[4] = 64'd7;                   bv[4] = 64'hFFFF_FFFF_FFFF_FFFE; ev[4] = 64'd1;
      fv[5] = F_DIVU; av[5] = 64'hFFFF_FFFF_FFFF_FFFF; bv[5] = 64'd10; ev[5] = 64'h1999_9999_9999_9999;
      fv[6] = F_REMU; av[6] = 64'hFFFF_FFFF_FFFF_FFFF; bv[6] = 64'd10; ev[6] = 64'd5;
      fv[7] = F_DIV;  av[7] = 64'hFFFF_FFFF_FFFF_FF9C; bv[7] = 64'hFFFF_FFFF_FFFF_FFF9; ev[7] = 64'd14;
      for (int i = 0; i < 8; i++) begin
         run_op(fv[i], 1'b0, av[i], bv[i], res, lat, bok);
         checks++;
         if (res !== ev[i] || lat !== NORMAL_LAT) begin
            errors++;
            $display("FAIL ops[%0d]: got %h lat %0d expected %h lat %0d",
                     i, res, lat, ev[i], NORMAL_LAT);
         end
      end
   endtask

   task automatic test_div_zero;
      logic [63:0] res;
      int          lat;
      logic        bok;
      run_op(F_DIVU, 1'b0, 64'd5, 64'd0, res, lat, bok);
      checks++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== SPECIAL_LAT) begin
         errors++;
         $display("FAIL divu_by_zero: got %h lat %0d expected %h lat %0d",
                  res, lat, 64'hFFFF_FFFF_FFFF_FFFF, SPECIAL_LAT);
      end
      run_op(F_REM, 1'b0, 64'd5, 64'd0, res, lat, bok);
      checks++;
      if (res !== 64'd5 || lat !== SPECIAL_LAT) begin
         errors++;
         $display("FAIL rem_by_zero: got %h lat %0d expected %h lat %0d",
                  res, lat, 64'd5, SPECIAL_LAT);
      end
   endtask

   task automatic test_overflow;
      logic [63:0] res;
      int          lat;
      logic        bok;
      run_op(F_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat, bok);
      checks++;
      if (res !== 64'h8000_0000_0000_0000 || lat !== SPECIAL_LAT) begin
         errors++;
         $display("FAIL div_overflow: got %h lat %0d expected %h lat %0d",
                  res, lat, 64'h8000_0000_0000_0000, SPECIAL_LAT);
      end
      run_op(F_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat, bok);
      checks++;
      if (res !== 64'h0 || lat !== SPECIAL_LAT) begin
         errors++;
         $display("FAIL rem_overflow: got %h lat %0d expected 0 lat %0d", res, lat, SPECIAL_LAT);
      end
   endtask

   task automatic test_word;
      logic [63:0] res;
      int          lat;
      logic        bok;
      run_op(F_DIV, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat, bok);
      checks++;
      if (res !== 64'hFFFF_FFFF_8000_0000) begin
         errors++;
         $display("FAIL divw: got %h expected %h", res, 64'hFFFF_FFFF_8000_0000);
      end
      run_op(F_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, res, lat, bok);
      checks++;
      if (res !== 64'h0000_0000_7FFF_FFFF) begin
         errors++;
         $display("FAIL divuw: got %h expected %h", res, 64'h0000_0000_7FFF_FFFF);
      end
   endtask

   task automatic test_flush;
      logic        seen;
      logic [63:0] res;
      int          lat;
      logic        bok;
      issue(F_DIVU, 1'b0, 64'd100, 64'd7);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_busy: in_ready=%b busy=%b out_valid=%b expected 1 0 0",
                  bus.in_ready, bus.busy, bus.out_valid);
      end
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid || bus.busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL flush_quiet: activity after flush got %b expected 0", seen);
      end
      bus.a = 64'd9; bus.b = 64'd3; bus.func = F_DIVU; bus.word = 1'b0;
      bus.in_valid = 1'b1;
      flush        = 1'b1;
      @(posedge clk); #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_accept: busy=%b in_ready=%b expected 0 1", bus.busy, bus.in_ready);
      end
      run_op(F_DIVU, 1'b0, 64'd100, 64'd7, res, lat, bok);
      checks++;
      if (res !== 64'd14 || lat !== NORMAL_LAT) begin
         errors++;
         $display("FAIL after_flush: got %h lat %0d expected %h lat %0d", res, lat, 64'd14, NORMAL_LAT);
      end
   endtask

   task automatic test_backpressure;
      int   lat;
      logic bok;
      issue(F_DIVU, 1'b0, 64'd100, 64'd7);
      wait_valid(lat, bok);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 64'd14) begin
         errors++;
         $display("FAIL bp_first: out_valid=%b result=%h expected 1 %h",
                  bus.out_valid, bus.result, 64'd14);
      end
      bus.a = 64'd55; bus.b = 64'd3; bus.func = F_DIV;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.result !== 64'd14 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: out_valid=%b result=%h in_ready=%b expected 1 %h 0",
                     i, bus.out_valid, bus.result, bus.in_ready, 64'd14);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_no_b2b: out_valid=%b busy=%b in_ready=%b expected 0 0 1",
                  bus.out_valid, bus.busy, bus.in_ready);
      end
   endtask

   task automatic test_reset_mid;
      issue(F_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      repeat (20) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 64'h0
          || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: out_valid=%b busy=%b result=%h in_ready=%b expected 0 0 0 1",
                  bus.out_valid, bus.busy, bus.result, bus.in_ready);
      end
   endtask

   initial begin
      reset         = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.func      = F_DIV;
      bus.word      = 1'b0;
      test_reset();
      test_div_basic();
      test_ops();
      test_div_zero();
      test_overflow();
      test_word();
      test_flush();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 64-bit integer divider in the execute stage, directly downstream of decode operand formation.
- Consumes decoded operands for DIV/DIVU/REM/REMU and their W forms.
- For W forms, decode has already sign- or zero-extended the operands to 64 bits.
- Stalls the pipeline through busy until the result is taken by the execute/memory register.

Parameters:
- XLEN, 64, operand/result width.
- ITERS, 64, radix-2 iterations per operation (equals XLEN).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  abort the in-flight operation
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept; high only in IDLE
- a  input  XLEN  dividend (rd1)
- b  input  XLEN  divisor (rd2)
- func  input  2  div_func_t: DIV=0, DIVU=1, REM=2, REMU=3
- word  input  1  ALUW variant: final result = sign-extend(result[31:0])
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  XLEN  quotient or remainder
- busy  output  1  high in BUSY or DONE; feeds stall logic

Behaviour:
- Single clock clk. Synchronous active-high reset: state=IDLE, counter=0, out_valid=0, result=0, busy=0; in_ready=1 from the first cycle after reset.
- FSM states:
  - IDLE -> BUSY on edge with in_valid && in_ready && !flush. Captures |a|, |b|, func, word, sign flags, zero/overflow flags; counter=ITERS-1.
  - BUSY: one restoring shift-subtract iteration per cycle. When counter==0 -> DONE; otherwise counter decrements.
  - DONE: out_valid=1, result held stable; DONE -> IDLE on out_ready.
- Latency: accept at edge N, out_valid visible after edge N+65 (64 BUSY cycles + 1).
- No back-to-back issue: in_ready=0 in DONE even when out_ready is high.
- Signed ops (DIV/REM): divide magnitudes unsigned.
  - Quotient negated if sign(a)!=sign(b).
  - Remainder takes sign of a.
  - Unsigned ops use raw values.
- Special cases (RISC-V):
  - b==0: quotient = all ones; remainder = a.
  - Signed a==0x8000_0000_0000_0000, b==-1: quotient = a; remainder = 0.
  - Flags are captured at accept; the output mux applies them regardless of iteration results.
- word=1: result = {32{r[31]}, r[31:0]}, taken after the sign fix.
- flush: in any state, next state IDLE, out_valid=0. Flush with in_valid in the same cycle: no accept.
- reset mid-operation: same as flush, plus result cleared.
- in_valid while not in_ready: ignored, no state change. Upstream must hold operands until accepted.
- result is registered; it does not change while out_valid=1.

Optional Feature:
- Macro DIV_FAST_PATH_EN.
- Defined: accept with b==0 or signed overflow goes IDLE -> DONE directly, so out_valid appears after edge N+1.
- Undefined: these cases still run all 64 BUSY cycles; the result values are identical in both builds.

Decomposition:
- In package pipes: typedef enum div_func_t (2 bits), typedef div_state_t {IDLE,BUSY,DONE}, localparam DIV_ITERS=64.
- Sub-module div_core_u64 holds the unsigned iterative core: start, 64-bit magnitudes, quotient/remainder registers, counter, done.
- div_unit owns the handshake, sign pre/post-processing, special cases, word extension and the FSM.

Test Plan:
- DIV a=0xFFFF_FFFF_FFFF_FFF9 (-7), b=2 -> result 0xFFFF_FFFF_FFFF_FFFD (-3); out_valid exactly 65 cycles after accept; busy high throughout.
- REM a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFF; REMU a=7, b=2 -> 1; DIVU a=100, b=7 -> 14.
- DIVU a=5, b=0 -> 0xFFFF_FFFF_FFFF_FFFF; REM a=5, b=0 -> 5; with DIV_FAST_PATH_EN, out_valid after 1 cycle, else after 65.
- DIV a=0x8000_0000_0000_0000, b=0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000; REM same operands -> 0.
- word: DIV a=0xFFFF_FFFF_8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000; DIVU a=0x0000_0000_FFFF_FFFE, b=2 -> 0x0000_0000_7FFF_FFFF.
- Handshake and abort cases:
  - flush on BUSY cycle 10 -> IDLE next cycle, no out_valid, in_ready=1.
  - out_ready low 5 cycles in DONE -> result stable, in_valid ignored.
  - reset mid-BUSY -> all outputs 0.
